// File: rtl/aes_sbox_unit.sv
// AES forward S-box for one byte: b = affine(inv(a)) over GF(2^8)/0x11B.
// Ports: clk, rst_n (sync, active-low), a[7:0] in, b[7:0] comb, b_q[7:0] reg.
module aes_sbox_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] b_q
);

  // GF(2^8) multiply, reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int unsigned n
  );
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  logic [7:0] sq [1:7];
  logic [7:0] inv_a;
  logic [7:0] sbox_d;
  logic [7:0] sbox_q;

  // inv(a) = a^254 = a^2 * a^4 * ... * a^128; squaring is
  // cheap (linear), so only six real multipliers are needed.
  // a = 0 falls out as 0 naturally.
  always_comb begin
    sq[1] = gf_mul(a, a);
    for (int k = 2; k < 8; k++) begin
      sq[k] = gf_mul(sq[k-1], sq[k-1]);
    end
    inv_a = sq[1];
    for (int k = 2; k < 8; k++) begin
      inv_a = gf_mul(inv_a, sq[k]);
    end
  end

  always_comb begin
    b = inv_a
      ^ rotl(inv_a, 1)
      ^ rotl(inv_a, 2)
      ^ rotl(inv_a, 3)
      ^ rotl(inv_a, 4)
      ^ 8'h63;
  end

  always_comb begin
    sbox_d = rst_n ? b : 8'h00;
  end

  always_ff @(posedge clk) begin
    sbox_q <= sbox_d;
  end

  assign b_q = sbox_q;

endmodule

// File: tb/tb_aes_sbox_unit.sv
// Randomized self-checking bench for aes_sbox_unit.
// Reference S-box built by brute-force inverse search + affine map.
module tb_aes_sbox_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] b_q;

  aes_sbox_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .b_q   (b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] ref_tbl [256];

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic int mul_mod(input int x, input int y);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((y >> i) & 1) p = p ^ (x << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if ((p >> i) & 1) p = p ^ (32'h11b << (i - 8));
    end
    return p;
  endfunction

  function automatic int rol8(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 8'hff;
  endfunction

  task automatic build_ref();
    int inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && mul_mod(x, y) == 1) inv = y;
      end
      s = inv ^ rol8(inv, 1) ^ rol8(inv, 2)
        ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      ref_tbl[x] = s[7:0];
    end
  endtask

  logic [7:0] kv_in  [7] = '{8'h00, 8'h01, 8'h10, 8'h53,
                             8'h7f, 8'h80, 8'hff};
  logic [7:0] kv_out [7] = '{8'h63, 8'h7c, 8'hca, 8'hed,
                             8'hd2, 8'hcd, 8'h16};

  initial begin
    logic [7:0] a_edge;
    build_ref();

    // reset
    rst_n = 1'b0;
    a     = 8'h53;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_bq", b_q, 8'h00);
    check("rst_b", b, 8'hed);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_bq", b_q, 8'hed);

    // known vectors, also sanity-check the model
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a = kv_in[i];
      #1;
      check($sformatf("kv_%h", kv_in[i]), b, kv_out[i]);
      check("kv_ref", ref_tbl[kv_in[i]], kv_out[i]);
    end

    // exhaustive sweep with a one-edge reset at C3
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a = i[7:0];
      rst_n = (i != 8'hc3);
      #1;
      check("sw_b", b, ref_tbl[i]);
      @(posedge clk);
      #1;
      if (i == 8'hc3) begin
        check("mid_rst_bq", b_q, 8'h00);
        check("mid_rst_b", b, 8'h2e);
      end else begin
        check("sw_bq", b_q, ref_tbl[i]);
      end
      if (i == 8'hc4) check("post_rst_bq", b_q, 8'h1c);
    end
    rst_n = 1'b1;

    // random: change a in both clock phases
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      #($urandom_range(1, 3));
      a = 8'($urandom);
      #1;
      check("rnd_b_lo", b, ref_tbl[a]);
      a_edge = a;
      @(posedge clk);
      #1;
      check("rnd_bq", b_q, ref_tbl[a_edge]);
      a = 8'($urandom);
      #1;
      check("rnd_b_hi", b, ref_tbl[a]);
    end

    // zero handling after FF
    @(negedge clk);
    a = 8'hff;
    #1;
    check("z_ff", b, 8'h16);
    a = 8'h00;
    #0;
    check("z_noX", {7'b0, $isunknown(b)}, 8'h00);
    #1;
    check("z_00", b, 8'h63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
